// File: rtl/motoro3_pkg.sv
// rtl/motoro3_pkg.sv - shared constants and FSM encoding for the motoro3 commutation blocks
package motoro3_pkg;

    localparam int CNT_W    = 25;
    localparam int STEP_NUM = 12;
    localparam int MIN_STEP = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } m3_state_e;

endpackage

// File: rtl/motoro3_step_timer.sv
// rtl/motoro3_step_timer.sv - step-length shadow, clamp, in-step down-counter and edge strobes
module motoro3_step_timer #(
    parameter int CNT_W    = 25,
    parameter int MIN_STEP = 4
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             clr,
    input  logic             load,
    input  logic             dec,
    input  logic             active,
    input  logic [CNT_W-1:0] step_len,
    output logic [CNT_W-1:0] cnt,
    output logic             first2,
    output logic             first1,
    output logic             last2,
    output logic             last1
);

    localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_STEP);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_clamp;
    logic             first2_q, first2_d;
    logic             first1_q, first1_d;
    logic             last2_q, last2_d;
    logic             last1_q, last1_d;

    assign len_clamp = (step_len < MIN_LEN) ? MIN_LEN : step_len;

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (clr) begin
            len_d = MIN_LEN;
            cnt_d = '0;
        end else if (load) begin
            len_d = len_clamp;
            cnt_d = len_clamp - ONE;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
        // Strobes are decoded from the next count so they line up with m3cnt
        first2_d = active && (cnt_d == len_d - ONE);
        first1_d = active && (cnt_d == len_d - TWO);
        last2_d  = active && (cnt_d == ONE);
        last1_d  = active && (cnt_d == '0);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            len_q    <= MIN_LEN;
            cnt_q    <= '0;
            first2_q <= 1'b0;
            first1_q <= 1'b0;
            last2_q  <= 1'b0;
            last1_q  <= 1'b0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            first2_q <= first2_d;
            first1_q <= first1_d;
            last2_q  <= last2_d;
            last1_q  <= last1_d;
        end
    end

    assign cnt    = cnt_q;
    assign first2 = first2_q;
    assign first1 = first1_q;
    assign last2  = last2_q;
    assign last1  = last1_q;

endmodule

// File: rtl/motoro3_step_sequencer.sv
// rtl/motoro3_step_sequencer.sv - 12-step commutation timing master feeding the PWM generators
module motoro3_step_sequencer
    import motoro3_pkg::*;
#(
    parameter int CNT_W    = motoro3_pkg::CNT_W,
    parameter int STEP_NUM = motoro3_pkg::STEP_NUM,
    parameter int MIN_STEP = motoro3_pkg::MIN_STEP
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             start,
    input  logic             stopReq,
    input  logic             abort,
    input  logic [CNT_W-1:0] m3r_stepLen,
    output logic [3:0]       sgStep,
    output logic [CNT_W-1:0] m3cnt,
    output logic             m3cntFirst2,
    output logic             m3cntFirst1,
    output logic             m3cntLast2,
    output logic             m3cntLast1,
    output logic             pwmActive1,
    output logic             pwmLastStep1,
    output logic [15:0]      revCnt,
    output logic             busy
);

    localparam logic [3:0] LAST_STEP = 4'(STEP_NUM - 1);

    m3_state_e   state_q, state_d;
    logic [3:0]  sg_step_q, sg_step_d;
    logic [15:0] rev_cnt_q, rev_cnt_d;
    logic        stop_pend_q, stop_pend_d;
    logic        active_q, active_d;
    logic        last_step_q, last_step_d;
    logic        busy_q, busy_d;
    logic        t_clr, t_load, t_dec;
    logic [15:0] rev_inc;

    assign rev_inc = (rev_cnt_q == 16'hFFFF) ? rev_cnt_q : rev_cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        sg_step_d   = sg_step_q;
        rev_cnt_d   = rev_cnt_q;
        stop_pend_d = stop_pend_q;
        t_clr       = 1'b0;
        t_load      = 1'b0;
        t_dec       = 1'b0;
        if (abort) begin
            state_d     = ST_IDLE;
            sg_step_d   = '0;
            stop_pend_d = 1'b0;
            t_clr       = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d     = ST_LOAD;
                        rev_cnt_d   = '0;
                        // A stop arriving with start is kept so the run ends after one cycle
                        stop_pend_d = stopReq;
                    end
                end
                ST_LOAD: begin
                    state_d     = ST_RUN;
                    sg_step_d   = '0;
                    rev_cnt_d   = '0;
                    stop_pend_d = stop_pend_q | stopReq;
                    t_load      = 1'b1;
                end
                ST_RUN: begin
                    if (stopReq) begin
                        stop_pend_d = 1'b1;
                    end
                    if (m3cnt == '0) begin
                        if (sg_step_q == LAST_STEP) begin
                            rev_cnt_d = rev_inc;
                        end
                        if ((stop_pend_q || stopReq) && (sg_step_q == LAST_STEP)) begin
                            state_d     = ST_IDLE;
                            sg_step_d   = '0;
                            stop_pend_d = 1'b0;
                            t_clr       = 1'b1;
                        end else begin
                            sg_step_d = (sg_step_q == LAST_STEP) ? 4'd0 : sg_step_q + 4'd1;
                            t_load    = 1'b1;
                        end
                    end else begin
                        t_dec = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    t_clr   = 1'b1;
                end
            endcase
        end
        active_d    = (state_d == ST_RUN);
        busy_d      = (state_d != ST_IDLE);
        last_step_d = active_d && stop_pend_d && (sg_step_d == LAST_STEP);
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state_q     <= ST_IDLE;
            sg_step_q   <= '0;
            rev_cnt_q   <= '0;
            stop_pend_q <= 1'b0;
            active_q    <= 1'b0;
            last_step_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sg_step_q   <= sg_step_d;
            rev_cnt_q   <= rev_cnt_d;
            stop_pend_q <= stop_pend_d;
            active_q    <= active_d;
            last_step_q <= last_step_d;
            busy_q      <= busy_d;
        end
    end

    motoro3_step_timer #(
        .CNT_W    (CNT_W),
        .MIN_STEP (MIN_STEP)
    ) u_timer (
        .clk      (clk),
        .nRst     (nRst),
        .clr      (t_clr),
        .load     (t_load),
        .dec      (t_dec),
        .active   (active_d),
        .step_len (m3r_stepLen),
        .cnt      (m3cnt),
        .first2   (m3cntFirst2),
        .first1   (m3cntFirst1),
        .last2    (m3cntLast2),
        .last1    (m3cntLast1)
    );

    assign sgStep       = sg_step_q;
    assign pwmActive1   = active_q;
    assign pwmLastStep1 = last_step_q;
    assign revCnt       = rev_cnt_q;
    assign busy         = busy_q;

endmodule
